// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_lsu
// Purpose  : MEM stage of an RV32 pipeline: load/store unit, byte-lane data
//            RAM and MEM/WB register. Handles SB/SH/SW and LB/LH/LW/LBU/LHU,
//            sign/zero extension, access-fault decode and a saturating fault
//            counter. Results appear one cycle after acceptance.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage_lsu #(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int FCNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m_valid,
  input  logic              m_rmem,
  input  logic              m_wmem,
  input  logic [2:0]        m_funct3,
  input  logic [XLEN-1:0]   m_alu,
  input  logic [XLEN-1:0]   m_b,
  input  logic [4:0]        m_rd,
  input  logic              m_wreg,
  output logic              w_valid,
  output logic [XLEN-1:0]   w_mo,
  output logic [XLEN-1:0]   w_alu,
  output logic [4:0]        w_rd,
  output logic              w_wreg,
  output logic              w_m2reg,
  output logic              w_fault,
  output logic [1:0]        w_fault_cause,
  output logic [FCNT_W-1:0] fault_count
);

  localparam int c_AW    = $clog2(DEPTH_WORDS);
  localparam int c_LANES = XLEN / 8;

  localparam logic [1:0] c_CAUSE_NONE  = 2'b00;
  localparam logic [1:0] c_CAUSE_ALIGN = 2'b01;
  localparam logic [1:0] c_CAUSE_F3    = 2'b10;
  localparam logic [1:0] c_CAUSE_BOTH  = 2'b11;

  logic [XLEN-1:0]   r_mem [DEPTH_WORDS];
  logic [XLEN-1:0]   r_rdata;
  logic              r_valid;
  logic [XLEN-1:0]   r_alu;
  logic [4:0]        r_rd;
  logic              r_wreg;
  logic              r_m2reg;
  logic              r_ld;
  logic [2:0]        r_f3;
  logic [1:0]        r_off;
  logic              r_fault;
  logic [1:0]        r_cause;
  logic [FCNT_W-1:0] r_fcnt;

  logic [c_AW-1:0]    w_word_idx;
  logic [1:0]         w_acc_cause;
  logic               w_acc_fault;
  logic [c_LANES-1:0] w_lane_be;
  logic [XLEN-1:0]    w_lane_data;
  logic               w_st_en;
  logic [7:0]         w_ld_byte;
  logic [15:0]        w_ld_half;
  logic [XLEN-1:0]    w_ld_data;
  logic               w_unused_addr;

  // Address bits above the RAM range are deliberately ignored (wrap-around).
  assign w_word_idx    = m_alu[c_AW+1:2];
  assign w_unused_addr = ^m_alu[XLEN-1:c_AW+2];

  // Fault decode with priority both-set > illegal funct3 > misaligned.
  always_comb begin
    w_acc_cause = c_CAUSE_NONE;
    if (m_rmem && m_wmem) begin
      w_acc_cause = c_CAUSE_BOTH;
    end else if (m_rmem && (m_funct3 == 3'b011 || m_funct3 == 3'b110 || m_funct3 == 3'b111)) begin
      w_acc_cause = c_CAUSE_F3;
    end else if (m_wmem && (m_funct3[2] || m_funct3 == 3'b011)) begin
      w_acc_cause = c_CAUSE_F3;
    end else if (m_rmem || m_wmem) begin
      if (m_funct3[1:0] == 2'b01 && m_alu[0])
        w_acc_cause = c_CAUSE_ALIGN;
      else if (m_funct3[1:0] == 2'b10 && m_alu[1:0] != 2'b00)
        w_acc_cause = c_CAUSE_ALIGN;
    end
  end
  assign w_acc_fault = (w_acc_cause != c_CAUSE_NONE);

  // Byte-lane enables and lane-replicated store data for SB/SH/SW.
  always_comb begin
    w_lane_be   = '0;
    w_lane_data = '0;
    case (m_funct3[1:0])
      2'b00: begin
        w_lane_be[m_alu[1:0]] = 1'b1;
        w_lane_data           = {c_LANES{m_b[7:0]}};
      end
      2'b01: begin
        w_lane_be   = m_alu[1] ? 4'b1100 : 4'b0011;
        w_lane_data = {(c_LANES/2){m_b[15:0]}};
      end
      2'b10: begin
        w_lane_be   = '1;
        w_lane_data = m_b;
      end
      default: ;
    endcase
  end
  assign w_st_en = m_valid && m_wmem && !w_acc_fault;

  // Data RAM: byte-lane writes (suppressed under reset) and synchronous read.
  always_ff @(posedge clk) begin
    if (!rst && w_st_en) begin
      for (int i = 0; i < c_LANES; i++) begin
        if (w_lane_be[i])
          r_mem[w_word_idx][8*i +: 8] <= w_lane_data[8*i +: 8];
      end
    end
    if (m_valid && m_rmem)
      r_rdata <= r_mem[w_word_idx];
  end

  // MEM/WB pipeline register; a fault kills write-back but keeps alu/rd.
  always_ff @(posedge clk) begin
    if (rst || !m_valid) begin
      r_valid <= 1'b0;
      r_alu   <= '0;
      r_rd    <= '0;
      r_wreg  <= 1'b0;
      r_m2reg <= 1'b0;
      r_ld    <= 1'b0;
      r_f3    <= '0;
      r_off   <= '0;
      r_fault <= 1'b0;
      r_cause <= c_CAUSE_NONE;
    end else begin
      r_valid <= 1'b1;
      r_alu   <= m_alu;
      r_rd    <= m_rd;
      r_wreg  <= m_wreg && !w_acc_fault;
      r_m2reg <= m_rmem && !w_acc_fault;
      r_ld    <= m_rmem && !w_acc_fault;
      r_f3    <= m_funct3;
      r_off   <= m_alu[1:0];
      r_fault <= w_acc_fault;
      r_cause <= w_acc_cause;
    end
  end

  // Saturating fault counter, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst)
      r_fcnt <= '0;
    else if (m_valid && w_acc_fault && r_fcnt != {FCNT_W{1'b1}})
      r_fcnt <= r_fcnt + FCNT_W'(1);
  end

  // Lane extraction and sign/zero extension of the registered read word.
  always_comb begin
    w_ld_byte = r_rdata[{r_off, 3'b000} +: 8];
    w_ld_half = r_off[1] ? r_rdata[31:16] : r_rdata[15:0];
    w_ld_data = '0;
    if (r_ld) begin
      case (r_f3)
        3'b000:  w_ld_data = {{(XLEN-8){w_ld_byte[7]}}, w_ld_byte};
        3'b100:  w_ld_data = {{(XLEN-8){1'b0}}, w_ld_byte};
        3'b001:  w_ld_data = {{(XLEN-16){w_ld_half[15]}}, w_ld_half};
        3'b101:  w_ld_data = {{(XLEN-16){1'b0}}, w_ld_half};
        3'b010:  w_ld_data = r_rdata;
        default: w_ld_data = '0;
      endcase
    end
  end

  assign w_valid       = r_valid;
  assign w_mo          = w_ld_data;
  assign w_alu         = r_alu;
  assign w_rd          = r_rd;
  assign w_wreg        = r_wreg;
  assign w_m2reg       = r_m2reg;
  assign w_fault       = r_fault;
  assign w_fault_cause = r_cause;
  assign fault_count   = r_fcnt;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage_lsu
// Purpose  : Self-checking bench for mem_stage_lsu: directed scenarios plus
//            random traffic against a byte-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage_lsu;

  localparam int DEPTH = 256;
  localparam int MEMB  = 4 * DEPTH;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        m_valid = 1'b0, m_rmem = 1'b0, m_wmem = 1'b0, m_wreg = 1'b0;
  logic [2:0]  m_funct3 = '0;
  logic [31:0] m_alu = '0, m_b = '0;
  logic [4:0]  m_rd = '0;
  logic        w_valid, w_wreg, w_m2reg, w_fault;
  logic [31:0] w_mo, w_alu;
  logic [4:0]  w_rd;
  logic [1:0]  w_fault_cause;
  logic [7:0]  fault_count;

  int vectors = 0;
  int miscompares = 0;

  // Reference state: byte-addressed memory and fault count.
  int unsigned mem_m [MEMB];
  int          cnt_m = 0;

  mem_stage_lsu #(.XLEN(32), .DEPTH_WORDS(DEPTH), .FCNT_W(8)) dut (
    .clk(clk), .rst(rst), .m_valid(m_valid), .m_rmem(m_rmem), .m_wmem(m_wmem),
    .m_funct3(m_funct3), .m_alu(m_alu), .m_b(m_b), .m_rd(m_rd), .m_wreg(m_wreg),
    .w_valid(w_valid), .w_mo(w_mo), .w_alu(w_alu), .w_rd(w_rd), .w_wreg(w_wreg),
    .w_m2reg(w_m2reg), .w_fault(w_fault), .w_fault_cause(w_fault_cause),
    .fault_count(fault_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int model_cause(input bit r, input bit w, input int f3, input int unsigned a);
    if (r && w) return 3;
    if (r && (f3 == 3 || f3 == 6 || f3 == 7)) return 2;
    if (w && (f3 >= 4 || f3 == 3)) return 2;
    if (r || w) begin
      if (f3 % 4 == 1 && a % 2 != 0) return 1;
      if (f3 % 4 == 2 && a % 4 != 0) return 1;
    end
    return 0;
  endfunction

  function automatic logic [31:0] model_load(input int f3, input int unsigned a);
    int unsigned base;
    longint v;
    base = a % MEMB;
    case (f3 % 4)
      0: v = mem_m[base];
      1: v = mem_m[base] + 256 * mem_m[base + 1];
      default: v = mem_m[base] + 256 * mem_m[base + 1] + 65536 * mem_m[base + 2]
                   + 16777216 * longint'(mem_m[base + 3]);
    endcase
    if (f3 == 0 && v >= 128) v = v - 256;
    if (f3 == 1 && v >= 32768) v = v - 65536;
    return 32'(v);
  endfunction

  task automatic model_store(input int f3, input int unsigned a, input int unsigned b);
    int unsigned base;
    int n;
    base = a % MEMB;
    n = (f3 == 0) ? 1 : (f3 == 1) ? 2 : 4;
    for (int k = 0; k < n; k++) mem_m[base + k] = (b >> (8 * k)) % 256;
  endtask

  // One accepted (or idle) cycle: compute expectation, apply, then compare.
  task automatic step(input bit v, input bit r, input bit w, input int f3,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, input bit wr);
    int c;
    logic [31:0] e_mo;
    @(negedge clk);
    m_valid = v; m_rmem = r; m_wmem = w; m_funct3 = 3'(f3);
    m_alu = a; m_b = b; m_rd = rd; m_wreg = wr;
    c = model_cause(r, w, f3, a);
    e_mo = (v && c == 0 && r) ? model_load(f3, a) : 32'h0;
    if (v && c == 0 && w) model_store(f3, a, b);
    if (v && c != 0 && cnt_m < 255) cnt_m++;
    @(posedge clk); #1;
    check("valid", 32'(w_valid), 32'(v));
    check("mo", w_mo, e_mo);
    check("alu", w_alu, v ? a : 32'h0);
    check("rd", 32'(w_rd), v ? 32'(rd) : 32'h0);
    check("wreg", 32'(w_wreg), 32'(v && c == 0 && wr));
    check("m2reg", 32'(w_m2reg), 32'(v && c == 0 && r));
    check("fault", 32'(w_fault), 32'(v && c != 0));
    check("cause", 32'(w_fault_cause), v ? 32'(c) : 32'h0);
    check("fcnt", 32'(fault_count), 32'(cnt_m));
  endtask

  task automatic apply_reset(input int cycles, input bit with_store);
    @(negedge clk);
    rst = 1'b1;
    m_valid = with_store; m_wmem = with_store; m_rmem = 1'b0; m_funct3 = 3'b010;
    m_alu = 32'h50; m_b = 32'h1111_1111; m_rd = 5'd7; m_wreg = 1'b1;
    cnt_m = 0;
    repeat (cycles) @(posedge clk);
    #1;
    check("rst_valid", 32'(w_valid), 0);
    check("rst_mo", w_mo, 0);
    check("rst_alu", w_alu, 0);
    check("rst_rd", 32'(w_rd), 0);
    check("rst_wreg_m2reg", {30'h0, w_wreg, w_m2reg}, 0);
    check("rst_fault", {29'h0, w_fault, w_fault_cause}, 0);
    check("rst_fcnt", 32'(fault_count), 0);
    @(negedge clk);
    rst = 1'b0;
    m_valid = 1'b0; m_wmem = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < MEMB; i++) mem_m[i] = 0;
    apply_reset(2, 1'b0);

    // Bring the RAM to a known all-zero state.
    for (int i = 0; i < DEPTH; i++) step(1, 0, 1, 2, 32'(4 * i), 0, 0, 0);

    // Store then word readback.
    step(1, 0, 1, 2, 32'h10, 32'hDEADBEEF, 0, 0);
    step(1, 1, 0, 2, 32'h10, 0, 5'd3, 1);
    check("tp_lw", w_mo, 32'hDEADBEEF);
    check("tp_fcnt0", 32'(fault_count), 0);

    // Byte store and sign/zero extension.
    step(1, 0, 1, 0, 32'h21, 32'h80, 0, 0);
    step(1, 1, 0, 0, 32'h21, 0, 5'd4, 1);
    check("tp_lb", w_mo, 32'hFFFFFF80);
    step(1, 1, 0, 4, 32'h21, 0, 5'd4, 1);
    check("tp_lbu", w_mo, 32'h00000080);
    step(1, 1, 0, 2, 32'h20, 0, 5'd4, 1);
    check("tp_lw_b", w_mo, 32'h00008000);

    // Halfword store and extension; low lanes of the word untouched.
    step(1, 0, 1, 1, 32'h32, 32'h8001, 0, 0);
    step(1, 1, 0, 1, 32'h32, 0, 5'd5, 1);
    check("tp_lh", w_mo, 32'hFFFF8001);
    step(1, 1, 0, 5, 32'h32, 0, 5'd5, 1);
    check("tp_lhu", w_mo, 32'h00008001);
    step(1, 1, 0, 2, 32'h30, 0, 5'd5, 1);
    check("tp_lw_h", w_mo, 32'h80010000);

    // Misaligned store faults and leaves memory alone.
    step(1, 0, 1, 2, 32'h41, 32'h12345678, 5'd6, 1);
    check("tp_mis_cause", 32'(w_fault_cause), 1);
    step(1, 1, 0, 2, 32'h40, 0, 5'd6, 1);
    check("tp_mis_lw", w_mo, 0);
    check("tp_fcnt1", 32'(fault_count), 1);

    // Illegal funct3, load+store, and counter saturation.
    step(1, 1, 0, 3, 32'h0, 0, 5'd1, 1);
    check("tp_f3_cause", 32'(w_fault_cause), 2);
    step(1, 1, 1, 2, 32'h0, 0, 5'd1, 1);
    check("tp_both_cause", 32'(w_fault_cause), 3);
    for (int i = 0; i < 300; i++) step(1, 1, 0, 7, $urandom, 0, 5'd2, 1);
    check("tp_sat", 32'(fault_count), 255);

    // Address wrap-around.
    step(1, 0, 1, 2, 32'h404, 32'hA5A5A5A5, 0, 0);
    step(1, 1, 0, 2, 32'h004, 0, 5'd9, 1);
    check("tp_wrap", w_mo, 32'hA5A5A5A5);

    // Reset with a store in the same cycle: store must be dropped.
    step(1, 0, 0, 0, 32'h1234, 0, 5'd10, 1);
    apply_reset(1, 1'b1);
    step(1, 1, 0, 2, 32'h50, 0, 5'd11, 1);
    check("tp_rst_store", w_mo, 0);

    // Random traffic, including idle slots and all fault classes.
    for (int i = 0; i < 600; i++) begin
      int kind;
      kind = $urandom_range(0, 6);
      step($urandom_range(0, 9) != 0, (kind >= 1 && kind <= 3) || kind == 6,
           kind == 4 || kind == 5 || kind == 6, $urandom_range(0, 7),
           $urandom, $urandom, 5'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
